lr35902_sram: RTL
=================

// Module: lr35902_sram
// PURPOSE
//   Parametrised single-port CPU-side RAM with strobe-edge access semantics, for HRAM,
//   WRAM banks and scratch buffers. Read commits on the rising edge of `read`; write commits on
//   the falling edge of `write`. After reset, a clear sequencer fills memory with a constant
//   before accepting accesses. Sits between the CPU bus decoder and the memory array.
// PARAMETERS
//   WIDTH   8    data width in bits
//   DEPTH   128  number of words; need not be a power of two
//   FILL    0    word written by the clear sweep; also returned by out-of-range reads
//   ADR_W   $clog2(DEPTH)  address width (derived, do not override)
// PORTS
//   clk    in   1      single clock; all logic on posedge
//   reset  in   1      synchronous, active-high reset
//   dout   out  WIDTH  read data, registered
//   din    in   WIDTH  write data, sampled in the commit cycle
//   adr    in   ADR_W  word address, sampled in the commit cycle
//   read   in   1      read strobe, level
//   write  in   1      write strobe, level
//   busy   out  1      high while the clear sweep runs; strobes are ignored
// BEHAVIOUR
//   - Edge history: r_read/r_write hold the previous cycle's read/write.
//     rd_ev = read & ~r_read; wr_ev = r_write & ~write. Both are evaluated every cycle.
//   - rd_ev: dout <= mem[adr] on that posedge; the data is visible the next cycle (latency 1).
//     dout holds between events.
//   - wr_ev: mem[adr] <= din on that posedge. Address and data are taken at the falling edge,
//     not at the rising edge.
//   - Simultaneous rd_ev and wr_ev at the same adr: write-first, so dout <= din.
//     At different addresses, both commit.
//   - adr >= DEPTH: the read returns FILL; the write is dropped silently.
//   - Reset values: dout = FILL. r_read/r_write are loaded with the current read/write, so no
//     edge fires from pre-reset strobe levels.
//   - Clear FSM (only with the macro below), states IDLE and CLEAR:
//       reset            -> CLEAR, cnt = 0, busy = 1
//       CLEAR            mem[cnt] <= FILL; cnt++; at cnt == DEPTH-1 -> IDLE next cycle
//       IDLE             busy = 0; normal access
//     The sweep lasts exactly DEPTH cycles after reset deasserts.
//   - Reset during CLEAR restarts the sweep at cnt = 0.
//   - During CLEAR, r_read/r_write track the strobes but rd_ev/wr_ev are suppressed.
//     Edges that fall inside CLEAR are lost and are not replayed. dout holds FILL.
// CONFIGURATION
//   LR35902_SRAM_CLEAR_EN defined:
//     - clear FSM and counter are present; behaviour as above.
//   LR35902_SRAM_CLEAR_EN undefined:
//     - no FSM and no counter; busy is tied 0.
//     - Memory contents after reset are undefined, so the array maps to plain block RAM.
//     - Accesses are accepted from the first cycle after reset.
// STRUCTURE
//   - Shared package lr35902_mem_pkg holds:
//       - the default WIDTH/DEPTH constants for HRAM (8/128) and WRAM (8/4096);
//       - the clear-FSM state encoding (ST_IDLE=1'b0, ST_CLEAR=1'b1).
//   - Sub-module lr35902_strobe_edge(clk, reset, hold, in, rise, fall), one instance per
//     strobe. It owns the history flop, the reset-load behaviour and suppression under `hold`.
//   - The memory array and the clear FSM stay in this module.
// TESTING
//   - CLEAR_EN, DEPTH=128, FILL=8'hFF: deassert reset.
//     -> busy=1 for exactly 128 cycles; then reading adr 0, 64 and 127 returns 8'hFF.
//   - Idle: write pulse, adr=7'h12, din=8'hA5 (adr/din changed before the rising edge).
//     -> mem[7'h12] = 8'hA5, taken from values at the falling edge; later read -> dout = 8'hA5.
//   - Hold read high 5 cycles at adr=7'h12. -> dout updates once, 1 cycle after the rise;
//     changing adr mid-pulse does not change dout.
//   - Read rise and write fall in the same cycle at adr=7'h20, din=8'h3C.
//     -> dout = 8'h3C next cycle and mem[7'h20] = 8'h3C.
//   - DEPTH=100: write 8'h55 to adr 100, then read adr 100.
//     -> dout = FILL; words 0..99 unchanged.
//   - Reasserting reset at cnt=50 restarts the sweep (busy high for another DEPTH cycles).
//     A write pulse during busy is lost.
//   - Without the macro: busy stays 0; a write then read on the first cycles after reset
//     round-trips correctly.

Source files
------------

// File: rtl/lr35902_mem_pkg.sv
// Shared constants for the LR35902 CPU-side RAMs: default HRAM/WRAM geometry
// and the state encoding of the optional clear sequencer.
package lr35902_mem_pkg;

  localparam int HRAM_WIDTH = 8;
  localparam int HRAM_DEPTH = 128;
  localparam int WRAM_WIDTH = 8;
  localparam int WRAM_DEPTH = 4096;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/lr35902_strobe_edge.sv
// Edge detector for one level strobe: rise fires on 0->1, fall on 1->0.
// Events are masked while hold or reset is high; the history flop keeps tracking.
module lr35902_strobe_edge (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  input  logic in,
  output logic rise,
  output logic fall
);

  logic r_in;

  // Reset loads the live level so a strobe already high before reset never
  // looks like a fresh edge afterwards.
  always_ff @(posedge clk) begin
    if (reset) r_in <= in;
    else       r_in <= in;
  end

  assign rise = in & ~r_in & ~hold & ~reset;
  assign fall = ~in & r_in & ~hold & ~reset;

endmodule

// File: rtl/lr35902_sram.sv
// Single-port CPU-side RAM: read commits on the rising edge of read, write on
// the falling edge of write. Define LR35902_SRAM_CLEAR_EN for the post-reset FILL sweep.
module lr35902_sram
  import lr35902_mem_pkg::*;
#(
  parameter int              WIDTH = HRAM_WIDTH,
  parameter int              DEPTH = HRAM_DEPTH,
  parameter logic [WIDTH-1:0] FILL = '0,
  parameter int              ADR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] dout,
  input  logic [WIDTH-1:0] din,
  input  logic [ADR_W-1:0] adr,
  input  logic             read,
  input  logic             write,
  output logic             busy
);

  localparam logic [ADR_W:0] DEPTH_W = (ADR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_dout;

  logic             w_hold;
  logic             w_rd_ev;
  logic             w_wr_ev;
  logic             w_rd_unused;
  logic             w_wr_unused;
  logic             w_in_range;
  logic             w_mem_we;
  logic [ADR_W-1:0] w_mem_adr;
  logic [WIDTH-1:0] w_mem_din;

  assign w_in_range = ({1'b0, adr} < DEPTH_W);

`ifdef LR35902_SRAM_CLEAR_EN
  clr_state_t       r_state;
  clr_state_t       w_state_nxt;
  logic [ADR_W-1:0] r_cnt;
  logic [ADR_W-1:0] w_cnt_nxt;
  logic             w_clr_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // One word per cycle; the last word (cnt == DEPTH-1) hands over to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr_we    = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        busy      = 1'b1;
        w_clr_we  = 1'b1;
        w_cnt_nxt = r_cnt + ADR_W'(1);
        if (r_cnt == ADR_W'(DEPTH - 1)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign w_hold    = busy;
  assign w_mem_we  = w_clr_we | (w_wr_ev & w_in_range);
  assign w_mem_adr = w_clr_we ? r_cnt : adr;
  assign w_mem_din = w_clr_we ? FILL : din;
`else
  assign busy      = 1'b0;
  assign w_hold    = 1'b0;
  assign w_mem_we  = w_wr_ev & w_in_range;
  assign w_mem_adr = adr;
  assign w_mem_din = din;
`endif

  lr35902_strobe_edge u_rd_edge (
    .clk   (clk),
    .reset (reset),
    .hold  (w_hold),
    .in    (read),
    .rise  (w_rd_ev),
    .fall  (w_rd_unused)
  );

  lr35902_strobe_edge u_wr_edge (
    .clk   (clk),
    .reset (reset),
    .hold  (w_hold),
    .in    (write),
    .rise  (w_wr_unused),
    .fall  (w_wr_ev)
  );

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_adr] <= w_mem_din;
  end

  // Write-first: a read and write committing together return the new data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout <= FILL;
    end else if (w_rd_ev) begin
      if (!w_in_range)  r_dout <= FILL;
      else if (w_wr_ev) r_dout <= din;
      else              r_dout <= r_mem[adr];
    end
  end

  assign dout = r_dout;

endmodule
